dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 = core load/store unit, port 1 = debug/DMA.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 tb/tb_dmem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 size codes, FSM states, port count.
// No logic of its own; imported by dmem_lane_align and dmem_arbiter.
package dmem_pkg;
   localparam int NPORT = 2;

   localparam logic [2:0] SZ_B  = 3'd0;
   localparam logic [2:0] SZ_H  = 3'd1;
   localparam logic [2:0] SZ_W  = 3'd2;
   localparam logic [2:0] SZ_BU = 3'd4;
   localparam logic [2:0] SZ_HU = 3'd5;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_LOCK1 = 1'b1
   } state_e;

   // 011 and 11x all decode as word accesses.
   function automatic logic is_word(input logic [2:0] sz);
      return sz[1] == SZ_W[1];
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane conversion: store mask/data placement and load extract/extend, plus alignment check.
// Purely combinational, zero latency; no backpressure.
// CHECK_ALIGN=1 flags halfwords with a[0]=1 and words with a[1:0]!=0.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter bit CHECK_ALIGN = 1'b0
) (
   input  logic [2:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wmask_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);
   logic [7:0]  rd_b;
   logic [15:0] rd_h;
   logic        sext;

   always_comb begin
      wmask_o    = 4'hF;
      wdata_o    = wdata_i;
      rdata_o    = rdata_i;
      misalign_o = 1'b0;
      sext       = !((size_i == SZ_BU) || (size_i == SZ_HU));
      case (off_i)
         2'd0:    rd_b = rdata_i[7:0];
         2'd1:    rd_b = rdata_i[15:8];
         2'd2:    rd_b = rdata_i[23:16];
         default: rd_b = rdata_i[31:24];
      endcase
      rd_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

      if (size_i[1:0] == SZ_B[1:0]) begin
         wmask_o = 4'b0001 << off_i;
         wdata_o = {4{wdata_i[7:0]}};
         rdata_o = {{24{sext & rd_b[7]}}, rd_b};
      end else if (size_i[1:0] == SZ_H[1:0]) begin
         wmask_o    = 4'b0011 << {off_i[1], 1'b0};
         wdata_o    = {2{wdata_i[15:0]}};
         rdata_o    = {{16{sext & rd_h[15]}}, rd_h};
         misalign_o = CHECK_ALIGN && off_i[0];
      end else if (is_word(size_i)) begin
         misalign_o = CHECK_ALIGN && (off_i != 2'b00);
      end
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between LSU (port 0) and debug/DMA (port 1).
// Grant is combinational in the access cycle; response (valid/rdata/err) is registered, one cycle later.
// Losing port stalls by holding its request; DMEM_MISALIGN_TRAP_EN turns misaligned accesses into errors.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NPORT-1:0]           req_i,
   input  logic [NPORT-1:0]           we_i,
   input  logic [NPORT-1:0][2:0]      size_i,
   input  logic [NPORT-1:0][AW-1:0]   addr_i,
   input  logic [NPORT-1:0][DW-1:0]   wdata_i,
   input  logic                       lock_i,
   output logic [NPORT-1:0]           gnt_o,
   output logic [NPORT-1:0]           rsp_valid_o,
   output logic [DW-1:0]              rsp_rdata_o,
   output logic                       rsp_err_o,
   output logic [AW-1:0]              mem_a_o,
   output logic [DW-1:0]              mem_wd_o,
   output logic                       mem_we_o,
   output logic [3:0]                 mem_wmask_o,
   input  logic [DW-1:0]              mem_rd_i
);
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   state_e           state_q;
   logic             last_q;
   logic [NPORT-1:0] rsp_valid_q;
   logic [DW-1:0]    rsp_rdata_q;
   logic [DW-1:0]    rsp_rdata_d;
   logic             rsp_err_q;

   logic [NPORT-1:0] gnt;
   logic             sel;
   logic             access;
   logic             misalign;
   logic             wr;
   logic [3:0]       lane_mask;
   logic [DW-1:0]    load_data;

   // While locked, port 1 owns the bus and port 0 never wins.
   always_comb begin
      gnt = '0;
      if (state_q == ST_LOCK1) begin
         gnt = {req_i[1], 1'b0};
      end else begin
         case (req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   assign sel    = gnt[1];
   assign access = |gnt;

   dmem_lane_align #(
      .CHECK_ALIGN(TRAP_EN)
   ) u_align (
      .size_i    (size_i[sel]),
      .off_i     (addr_i[sel][1:0]),
      .wdata_i   (wdata_i[sel]),
      .rdata_i   (mem_rd_i),
      .wmask_o   (lane_mask),
      .wdata_o   (mem_wd_o),
      .rdata_o   (load_data),
      .misalign_o(misalign)
   );

   assign wr          = access & we_i[sel] & ~misalign;
   assign mem_we_o    = wr;
   assign mem_wmask_o = wr ? lane_mask : 4'h0;
   assign mem_a_o     = {addr_i[sel][AW-1:2], 2'b00};

   assign rsp_rdata_d = (access && !we_i[sel] && !misalign) ? load_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ARB;
         last_q      <= 1'b1;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= gnt;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= access & misalign;
         if (access) last_q <= sel;
         case (state_q)
            ST_ARB:   if (gnt[1] && lock_i) state_q <= ST_LOCK1;
            ST_LOCK1: if (!lock_i) state_q <= ST_ARB;
            default:  state_q <= ST_ARB;
         endcase
      end
   end

   assign gnt_o       = gnt;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a byte-array memory model.
module tb_dmem_arbiter;
   localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2, SBU = 3'd4, SHU = 3'd5;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req, we;
   logic [1:0][2:0]  size;
   logic [1:0][31:0] addr, wdata;
   logic             lock;
   logic [1:0]       gnt, rsp_valid;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic [31:0]      mem_a, mem_wd, mem_rd;
   logic             mem_we;
   logic [3:0]       mem_wmask;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] env_mem [0:63];

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst), .req_i(req), .we_i(we), .size_i(size), .addr_i(addr),
      .wdata_i(wdata), .lock_i(lock), .gnt_o(gnt), .rsp_valid_o(rsp_valid),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .mem_a_o(mem_a), .mem_wd_o(mem_wd),
      .mem_we_o(mem_we), .mem_wmask_o(mem_wmask), .mem_rd_i(mem_rd)
   );

   assign mem_rd = env_mem[mem_a[7:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) env_mem[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end
   end

   task automatic set_port(input int p, input logic r, input logic w, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
      req[p] = r; we[p] = w; size[p] = sz; addr[p] = a; wdata[p] = d;
   endtask

   task automatic clear_inputs();
      req = '0; we = '0; size = '0; addr = '0; wdata = '0; lock = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp valid=%b rdata=%h err=%b required 00 00000000 0", rsp_valid, rsp_rdata, rsp_err);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (gnt !== 2'b00 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL idle_gnt gnt=%b we=%b required 00 0", gnt, mem_we);
      end
      set_port(0, 1, 0, SW, 32'h0, 32'h0);
      set_port(1, 1, 0, SW, 32'h4, 32'h0);
      #1;
      vectors++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL reset_tie gnt=%b required 01", gnt);
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic p0_access(input string name, input logic w, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                            input logic [31:0] exp_rdata, input logic exp_err);
      clear_inputs();
      set_port(0, 1, w, sz, a, d);
      #1;
      vectors++;
      if (gnt !== 2'b01 || mem_a !== {a[31:2], 2'b00} || mem_wmask !== exp_mask ||
          mem_we !== (exp_mask != 4'h0) || (exp_mask != 4'h0 && mem_wd !== exp_wd)) begin
         errors++;
         $display("FAIL %s_drive gnt=%b a=%h mask=%h we=%b wd=%h required 01 %h %h %b %h",
                  name, gnt, mem_a, mem_wmask, mem_we, mem_wd, {a[31:2], 2'b00}, exp_mask,
                  exp_mask != 4'h0, exp_wd);
      end
      @(negedge clk);
      clear_inputs();
      vectors++;
      if (rsp_valid !== 2'b01 || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
         errors++;
         $display("FAIL %s_rsp valid=%b rdata=%h err=%b required 01 %h %b",
                  name, rsp_valid, rsp_rdata, rsp_err, exp_rdata, exp_err);
      end
   endtask

   task automatic test_store_load();
      p0_access("sw",  1, SW,  32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 32'h0, 0);
      p0_access("lw",  0, SW,  32'h10, 32'h0, 4'h0, 32'h0, 32'hDEADBEEF, 0);
      p0_access("sb",  1, SB,  32'h13, 32'h00000080, 4'b1000, 32'h80808080, 32'h0, 0);
      p0_access("lb",  0, SB,  32'h13, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80, 0);
      p0_access("lbu", 0, SBU, 32'h13, 32'h0, 4'h0, 32'h0, 32'h00000080, 0);
      p0_access("lw2", 0, SW,  32'h10, 32'h0, 4'h0, 32'h0, 32'h80ADBEEF, 0);
      p0_access("sh",  1, SH,  32'h16, 32'h0000A5F0, 4'b1100, 32'hA5F0A5F0, 32'h0, 0);
      p0_access("lh",  0, SH,  32'h16, 32'h0, 4'h0, 32'h0, 32'hFFFFA5F0, 0);
      p0_access("lhu", 0, SHU, 32'h16, 32'h0, 4'h0, 32'h0, 32'h0000A5F0, 0);
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_g [4];
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         set_port(0, 1, 0, SW, 32'h10, 32'h0);
         set_port(1, 1, 0, SW, 32'h10, 32'h0);
         #1;
         vectors++;
         if (gnt !== exp_g[k]) begin
            errors++;
            $display("FAIL rr_gnt%0d gnt=%b required %b", k, gnt, exp_g[k]);
         end
         @(negedge clk);
         vectors++;
         if (rsp_valid !== exp_g[k] || rsp_rdata !== 32'h80ADBEEF) begin
            errors++;
            $display("FAIL rr_rsp%0d valid=%b rdata=%h required %b 80adbeef", k, rsp_valid, rsp_rdata, exp_g[k]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_lock();
      logic [1:0] lk_req [5];
      logic       lk_lock [5];
      logic [1:0] exp_g [5];
      lk_req  = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
      lk_lock = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_g   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
      do_reset();
      for (int k = 0; k < 5; k++) begin
         set_port(0, lk_req[k][0], 0, SW, 32'h10, 32'h0);
         set_port(1, lk_req[k][1], 0, SW, 32'h10, 32'h0);
         lock = lk_lock[k];
         #1;
         vectors++;
         if (gnt !== exp_g[k]) begin
            errors++;
            $display("FAIL lock_gnt%0d gnt=%b required %b", k, gnt, exp_g[k]);
         end
         @(negedge clk);
         vectors++;
         if (rsp_valid !== exp_g[k]) begin
            errors++;
            $display("FAIL lock_rsp%0d valid=%b required %b", k, rsp_valid, exp_g[k]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_misalign();
      p0_access("sw_base", 1, SW, 32'h10, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 32'h0, 0);
      if (TRAP) begin
         p0_access("sw_mis", 1, SW, 32'h12, 32'h11223344, 4'h0, 32'h0, 32'h0, 1);
         p0_access("lw_mis", 0, SW, 32'h12, 32'h0, 4'h0, 32'h0, 32'h0, 1);
         p0_access("lw_chk", 0, SW, 32'h10, 32'h0, 4'h0, 32'h0, 32'hCAFEF00D, 0);
      end else begin
         p0_access("sw_mis", 1, SW, 32'h12, 32'h11223344, 4'hF, 32'h11223344, 32'h0, 0);
         p0_access("lh_odd", 0, SH, 32'h13, 32'h0, 4'h0, 32'h0, 32'h00001122, 0);
         p0_access("lw_chk", 0, SW, 32'h10, 32'h0, 4'h0, 32'h0, 32'h11223344, 0);
      end
   endtask

   task automatic test_rst_mid_lock();
      do_reset();
      set_port(1, 1, 0, SW, 32'h10, 32'h0);
      lock = 1'b1;
      @(negedge clk);
      set_port(0, 1, 0, SW, 32'h10, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      lock = 1'b0;
      #1;
      vectors++;
      if (gnt !== 2'b01 || rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL rst_lock gnt=%b valid=%b required 01 00", gnt, rsp_valid);
      end
      clear_inputs();
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0]  mm [0:255];
      logic [2:0]  sz_tab [8];
      bit          m_lock, m_last;
      logic [1:0]  eg, p_vld;
      logic [31:0] p_rdata, a, d, v;
      logic        p_err, w, mis, exp_we;
      logic [2:0]  sz;
      int          p, base, nb;
      sz_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
      for (int i = 0; i < 256; i++) mm[i] = 8'h00;
      for (int i = 32; i < 64; i++) env_mem[i] = 32'h0;
      do_reset();
      m_lock = 0; m_last = 1; p_vld = 2'b00; p_rdata = 0; p_err = 0;
      for (int it = 0; it < 600; it++) begin
         vectors++;
         if (rsp_valid !== p_vld || (p_vld != 0 && (rsp_rdata !== p_rdata || rsp_err !== p_err))) begin
            errors++;
            $display("FAIL rnd_rsp it=%0d valid=%b rdata=%h err=%b required %b %h %b",
                     it, rsp_valid, rsp_rdata, rsp_err, p_vld, p_rdata, p_err);
         end
         for (int q = 0; q < 2; q++)
            set_port(q, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), sz_tab[$urandom_range(0, 7)],
                     32'd128 + 32'($urandom_range(0, 127)), $urandom);
         lock = $urandom_range(0, 3) != 0;
         #1;
         if (m_lock) eg = req[1] ? 2'b10 : 2'b00;
         else if (req == 2'b11) eg = m_last ? 2'b01 : 2'b10;
         else eg = req;
         exp_we = 0;
         p_vld = eg; p_rdata = 0; p_err = 0;
         if (eg != 0) begin
            p  = eg[1] ? 1 : 0;
            sz = size[p]; a = addr[p]; d = wdata[p]; w = we[p];
            nb = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
            base = int'(a) & ~(nb - 1);
            mis  = TRAP && (int'(a) != base);
            p_err = mis;
            if (!mis && w) begin
               exp_we = 1;
               for (int k = 0; k < nb; k++) mm[base + k] = d[8*k +: 8];
            end else if (!mis) begin
               v = 0;
               for (int k = 0; k < nb; k++) v[8*k +: 8] = mm[base + k];
               if (sz[2] == 0 && nb == 1) v = {{24{v[7]}}, v[7:0]};
               if (sz[2] == 0 && nb == 2) v = {{16{v[15]}}, v[15:0]};
               p_rdata = v;
            end
            m_last = eg[1];
         end
         if (m_lock) m_lock = lock;
         else m_lock = eg[1] && lock;
         vectors++;
         if (gnt !== eg || mem_we !== exp_we) begin
            errors++;
            $display("FAIL rnd_gnt it=%0d gnt=%b we=%b required %b %b", it, gnt, mem_we, eg, exp_we);
         end
         @(negedge clk);
      end
      clear_inputs();
      vectors++;
      if (rsp_valid !== p_vld || (p_vld != 0 && (rsp_rdata !== p_rdata || rsp_err !== p_err))) begin
         errors++;
         $display("FAIL rnd_last valid=%b rdata=%h err=%b required %b %h %b",
                  rsp_valid, rsp_rdata, rsp_err, p_vld, p_rdata, p_err);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) env_mem[i] = 32'h0;
      clear_inputs();
      rst = 1'b1;
      @(negedge clk);
      test_reset();
      test_store_load();
      test_round_robin();
      test_lock();
      test_misalign();
      test_rst_mid_lock();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
